// File: rtl/axi_sram_responder.sv
// Single-beat AXI target serving writes and reads from a synchronous single-port SRAM.
// Requests outside the [BASE, BASE + 4*2^MEM_AW) window get SLVERR and never strobe the SRAM.
module axi_sram_responder #(
    parameter int unsigned ID_W   = 4,
    parameter int unsigned MEM_AW = 10,
    parameter logic [31:0] BASE   = 32'h0000_0000
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic [ID_W-1:0]   AWID,
    input  logic [31:0]       AWADDR,
    input  logic              AWVALID,
    output logic              AWREADY,
    input  logic [31:0]       WDATA,
    input  logic [3:0]        WSTRB,
    input  logic              WVALID,
    output logic              WREADY,
    output logic [ID_W-1:0]   BID,
    output logic [1:0]        BRESP,
    output logic              BVALID,
    input  logic              BREADY,
    input  logic [ID_W-1:0]   ARID,
    input  logic [31:0]       ARADDR,
    input  logic              ARVALID,
    output logic              ARREADY,
    output logic [ID_W-1:0]   RID,
    output logic [31:0]       RDATA,
    output logic [1:0]        RRESP,
    output logic              RVALID,
    input  logic              RREADY,
    output logic [MEM_AW-1:0] addr,
    output logic [31:0]       dataOut,
    output logic [3:0]        en,
    output logic              we,
    output logic              cs,
    input  logic [31:0]       dataIn
);

    localparam logic [31:0] WIN_BYTES = 32'd4 << MEM_AW;
    localparam logic [1:0]  RESP_OKAY = 2'b00;
    localparam logic [1:0]  RESP_SLV  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD_REQ,
        S_RD_CAP,
        S_B_HOLD,
        S_R_HOLD
    } state_e;

    state_e            state_q, state_d;
    logic              last_rd_q, last_rd_d;

    logic              aw_full_q, aw_full_d;
    logic [ID_W-1:0]   aw_id_q;
    logic [31:0]       aw_addr_q;
    logic              w_full_q, w_full_d;
    logic [31:0]       w_data_q;
    logic [3:0]        w_strb_q;
    logic              ar_full_q, ar_full_d;
    logic [ID_W-1:0]   ar_id_q;
    logic [31:0]       ar_addr_q;

    logic [ID_W-1:0]   bid_q;
    logic [1:0]        bresp_q;
    logic [ID_W-1:0]   rid_q;
    logic [31:0]       rdata_q;
    logic [1:0]        rresp_q;

    logic              aw_hs, w_hs, ar_hs;
    logic              wr_elig, rd_elig, grant_wr, grant_rd;
    logic              arb, aw_clr, ar_clr, b_load, r_load;
    logic [31:0]       aw_off, ar_off;
    logic              aw_in_win, ar_in_win;

    assign AWREADY = !aw_full_q;
    assign WREADY  = !w_full_q;
    assign ARREADY = !ar_full_q;

    assign aw_hs = AWVALID && !aw_full_q;
    assign w_hs  = WVALID  && !w_full_q;
    assign ar_hs = ARVALID && !ar_full_q;

    // Eligibility includes this cycle's handshakes so a request accepted at T is served at T+1.
    assign wr_elig  = (aw_full_q || aw_hs) && (w_full_q || w_hs);
    assign rd_elig  = ar_full_q || ar_hs;
    assign grant_wr = wr_elig && (!rd_elig || last_rd_q);
    assign grant_rd = rd_elig && !grant_wr;

    assign aw_off    = aw_addr_q - BASE;
    assign ar_off    = ar_addr_q - BASE;
    assign aw_in_win = aw_off < WIN_BYTES;
    assign ar_in_win = ar_off < WIN_BYTES;

    assign BVALID = (state_q == S_B_HOLD);
    assign RVALID = (state_q == S_R_HOLD);
    assign BID    = bid_q;
    assign BRESP  = bresp_q;
    assign RID    = rid_q;
    assign RDATA  = rdata_q;
    assign RRESP  = rresp_q;

    always_comb begin
        state_d   = state_q;
        last_rd_d = last_rd_q;
        arb       = 1'b0;
        aw_clr    = 1'b0;
        ar_clr    = 1'b0;
        b_load    = 1'b0;
        r_load    = 1'b0;
        cs        = 1'b0;
        we        = 1'b0;
        en        = '0;
        addr      = '0;
        dataOut   = '0;
        unique case (state_q)
            S_IDLE: arb = 1'b1;
            S_WR: begin
                if (aw_in_win) begin
                    cs      = 1'b1;
                    we      = 1'b1;
                    en      = w_strb_q;
                    addr    = aw_off[MEM_AW+1:2];
                    dataOut = w_data_q;
                end
                aw_clr  = 1'b1;
                b_load  = 1'b1;
                state_d = S_B_HOLD;
            end
            S_RD_REQ: begin
                if (ar_in_win) begin
                    cs   = 1'b1;
                    en   = '1;
                    addr = ar_off[MEM_AW+1:2];
                end
                state_d = S_RD_CAP;
            end
            S_RD_CAP: begin
                r_load  = 1'b1;
                ar_clr  = 1'b1;
                state_d = S_R_HOLD;
            end
            // The handshake cycle doubles as the IDLE decision so back-to-back writes reach 1 per 2 cycles.
            S_B_HOLD: arb = BREADY;
            S_R_HOLD: arb = RREADY;
            default:  state_d = S_IDLE;
        endcase
        if (arb) begin
            state_d = S_IDLE;
            if (grant_wr) begin
                state_d   = S_WR;
                last_rd_d = 1'b0;
            end else if (grant_rd) begin
                state_d   = S_RD_REQ;
                last_rd_d = 1'b1;
            end
        end
    end

    always_comb begin
        aw_full_d = aw_hs ? 1'b1 : (aw_clr ? 1'b0 : aw_full_q);
        w_full_d  = w_hs  ? 1'b1 : (aw_clr ? 1'b0 : w_full_q);
        ar_full_d = ar_hs ? 1'b1 : (ar_clr ? 1'b0 : ar_full_q);
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q   <= S_IDLE;
            last_rd_q <= 1'b1;
            aw_full_q <= 1'b0;
            w_full_q  <= 1'b0;
            ar_full_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_rd_q <= last_rd_d;
            aw_full_q <= aw_full_d;
            w_full_q  <= w_full_d;
            ar_full_q <= ar_full_d;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            aw_id_q   <= '0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            ar_id_q   <= '0;
            ar_addr_q <= '0;
        end else begin
            if (aw_hs) begin
                aw_id_q   <= AWID;
                aw_addr_q <= AWADDR;
            end
            if (w_hs) begin
                w_data_q <= WDATA;
                w_strb_q <= WSTRB;
            end
            if (ar_hs) begin
                ar_id_q   <= ARID;
                ar_addr_q <= ARADDR;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            bid_q   <= '0;
            bresp_q <= '0;
            rid_q   <= '0;
            rdata_q <= '0;
            rresp_q <= '0;
        end else begin
            if (b_load) begin
                bid_q   <= aw_id_q;
                bresp_q <= aw_in_win ? RESP_OKAY : RESP_SLV;
            end
            if (r_load) begin
                rid_q   <= ar_id_q;
                rdata_q <= ar_in_win ? dataIn : '0;
                rresp_q <= ar_in_win ? RESP_OKAY : RESP_SLV;
            end
        end
    end

endmodule

// File: tb/tb_axi_sram_responder.sv
// Directed bench for axi_sram_responder with a behavioural SRAM and an access log.
module tb_axi_sram_responder;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic [3:0]  AWID, BID, ARID, RID;
    logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [3:0]  WSTRB, en;
    logic [1:0]  BRESP, RRESP;
    logic [9:0]  addr;
    logic [31:0] dataOut, dataIn;
    logic        we, cs;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [0:1023];
    logic [10:0] sram_log [$];

    always #5 ACLK = ~ACLK;

    axi_sram_responder #(.ID_W(4), .MEM_AW(10), .BASE(32'h0000_0000)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWID(AWID), .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .addr(addr), .dataOut(dataOut), .en(en), .we(we), .cs(cs), .dataIn(dataIn)
    );

    always @(posedge ACLK) begin
        if (cs) begin
            sram_log.push_back({we, addr});
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (en[b]) mem[addr][8*b +: 8] <= dataOut[8*b +: 8];
            end else begin
                dataIn <= mem[addr];
            end
        end
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    int n0;

    initial begin
        ARESETn = 1'b0;
        AWID = '0; AWADDR = '0; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b0;
        ARID = '0; ARADDR = '0; ARVALID = 1'b0; RREADY = 1'b0;
        dataIn = '0;
        #12;
        chk("rst_ready", {29'b0, AWREADY, WREADY, ARREADY}, 32'h7);
        chk("rst_valid", {30'b0, BVALID, RVALID}, 32'h0);
        chk("rst_ids", {24'b0, BID, RID}, 32'h0);
        chk("rst_resp", {28'b0, BRESP, RRESP}, 32'h0);
        chk("rst_rdata", RDATA, 32'h0);
        chk("rst_sram", {16'b0, cs, we, en, addr}, 32'h0);
        chk("rst_dataout", dataOut, 32'h0);
        @(posedge ACLK); #1;
        ARESETn = 1'b1;
        tick();

        // Write, AW and W together
        BREADY = 1'b1; RREADY = 1'b1;
        AWVALID = 1'b1; AWID = 4'd3; AWADDR = 32'h10;
        WVALID = 1'b1; WDATA = 32'hDEADBEEF; WSTRB = 4'hF;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0;
        chk("w1_strobe", {16'b0, cs, we, en, addr}, {16'b0, 1'b1, 1'b1, 4'hF, 10'd4});
        chk("w1_data", dataOut, 32'hDEADBEEF);
        chk("w1_ready_low", {30'b0, AWREADY, WREADY}, 32'h0);
        chk("w1_bvalid_early", {31'b0, BVALID}, 32'h0);
        tick();
        chk("w1_bresp", {25'b0, BVALID, BID, BRESP}, {25'b0, 1'b1, 4'd3, 2'b00});
        chk("w1_cs_pulse", {30'b0, cs, AWREADY}, 32'h1);
        tick();
        chk("w1_bdone", {31'b0, BVALID}, 32'h0);

        // Write with W one cycle ahead of AW, partial strobe, then read back
        WVALID = 1'b1; WDATA = 32'h11223344; WSTRB = 4'b0101;
        tick();
        WVALID = 1'b0;
        AWVALID = 1'b1; AWID = 4'd1; AWADDR = 32'h10;
        chk("w2_wready_low", {30'b0, WREADY, cs}, 32'h0);
        tick();
        AWVALID = 1'b0;
        chk("w2_strobe", {16'b0, cs, we, en, addr}, {16'b0, 1'b1, 1'b1, 4'b0101, 10'd4});
        tick();
        chk("w2_bresp", {25'b0, BVALID, BID, BRESP}, {25'b0, 1'b1, 4'd1, 2'b00});
        tick();
        ARVALID = 1'b1; ARID = 4'd5; ARADDR = 32'h10;
        tick();
        ARVALID = 1'b0;
        chk("r2_strobe", {16'b0, cs, we, en, addr}, {16'b0, 1'b1, 1'b0, 4'hF, 10'd4});
        chk("r2_req_flags", {30'b0, ARREADY, RVALID}, 32'h0);
        tick();
        chk("r2_cap_flags", {29'b0, ARREADY, RVALID, cs}, 32'h0);
        tick();
        chk("r2_rvalid", {25'b0, RVALID, RID, RRESP}, {25'b0, 1'b1, 4'd5, 2'b00});
        chk("r2_rdata", RDATA, 32'hDE22BE44);
        chk("r2_arready", {31'b0, ARREADY}, 32'h1);
        tick();
        chk("r2_rdone", {31'b0, RVALID}, 32'h0);

        // Out-of-window write and read
        n0 = sram_log.size();
        AWVALID = 1'b1; AWID = 4'd2; AWADDR = 32'h1000;
        WVALID = 1'b1; WDATA = 32'hCAFEF00D; WSTRB = 4'hF;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0;
        chk("oow_w_nocs", {31'b0, cs}, 32'h0);
        tick();
        chk("oow_w_bresp", {25'b0, BVALID, BID, BRESP}, {25'b0, 1'b1, 4'd2, 2'b10});
        tick();
        ARVALID = 1'b1; ARID = 4'd7; ARADDR = 32'hFFFF_FFF0;
        tick();
        ARVALID = 1'b0;
        chk("oow_r_nocs", {31'b0, cs}, 32'h0);
        tick();
        tick();
        chk("oow_r_resp", {25'b0, RVALID, RID, RRESP}, {25'b0, 1'b1, 4'd7, 2'b10});
        chk("oow_r_rdata", RDATA, 32'h0);
        chk("oow_no_access", sram_log.size(), n0);
        tick();

        // Write pair and AR presented together four times: writes and reads must alternate
        sram_log.delete();
        for (int k = 0; k < 4; k++) begin
            AWVALID = 1'b1; AWID = 4'd8; AWADDR = 32'h20 + 32'(4 * k);
            WVALID = 1'b1; WDATA = 32'hA000_0000 + 32'(k); WSTRB = 4'hF;
            ARVALID = 1'b1; ARID = 4'd9; ARADDR = 32'h20 + 32'(4 * k);
            tick();
            AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
            tick(); tick(); tick(); tick();
            chk("arb_rvalid", {31'b0, RVALID}, 32'h1);
            chk("arb_rdata", RDATA, 32'hA000_0000 + 32'(k));
            tick();
        end
        chk("arb_log_size", sram_log.size(), 32'd8);
        for (int k = 0; k < 4; k++) begin
            chk("arb_order_w", {21'b0, sram_log[2*k]}, {21'b0, 1'b1, 10'(8 + k)});
            chk("arb_order_r", {21'b0, sram_log[2*k+1]}, {21'b0, 1'b0, 10'(8 + k)});
        end

        // BREADY held low for 5 cycles while a read gets queued
        BREADY = 1'b0;
        AWVALID = 1'b1; AWID = 4'd9; AWADDR = 32'h30;
        WVALID = 1'b1; WDATA = 32'h5A5A_1234; WSTRB = 4'hF;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0;
        tick();
        ARVALID = 1'b1; ARID = 4'd2; ARADDR = 32'h30;
        for (int i = 0; i < 5; i++) begin
            chk("bhold_stable", {24'b0, BVALID, cs, BID, BRESP}, {24'b0, 1'b1, 1'b0, 4'd9, 2'b00});
            tick();
            ARVALID = 1'b0;
        end
        chk("bhold_ar_captured", {30'b0, ARREADY, BVALID}, 32'h1);
        BREADY = 1'b1;
        tick();
        chk("bhold_rd_after", {20'b0, BVALID, cs, we, addr}, {20'b0, 1'b0, 1'b1, 1'b0, 10'd12});
        tick(); tick();
        chk("bhold_rresp", {25'b0, RVALID, RID, RRESP}, {25'b0, 1'b1, 4'd2, 2'b00});
        chk("bhold_rdata", RDATA, 32'h5A5A_1234);
        tick();

        // Reset pulsed during RD_CAP
        ARVALID = 1'b1; ARID = 4'd6; ARADDR = 32'h30;
        tick();
        ARVALID = 1'b0;
        tick();
        chk("mid_pre_arready", {31'b0, ARREADY}, 32'h0);
        ARESETn = 1'b0;
        #1;
        chk("mid_rst_flags", {27'b0, RVALID, BVALID, cs, ARREADY, AWREADY}, 32'h3);
        chk("mid_rst_ids", {24'b0, BID, RID}, 32'h0);
        chk("mid_rst_rdata", RDATA, 32'h0);
        tick();
        tick();
        ARESETn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("mid_no_resp", {30'b0, RVALID, cs}, 32'h0);
            tick();
        end
        AWVALID = 1'b1; AWID = 4'd4; AWADDR = 32'h44;
        WVALID = 1'b1; WDATA = 32'h0BADF00D; WSTRB = 4'hF;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0;
        chk("post_w_strobe", {20'b0, cs, we, addr}, {20'b0, 1'b1, 1'b1, 10'h11});
        tick();
        chk("post_bresp", {25'b0, BVALID, BID, BRESP}, {25'b0, 1'b1, 4'd4, 2'b00});
        tick();
        ARVALID = 1'b1; ARID = 4'hA; ARADDR = 32'h44;
        tick();
        ARVALID = 1'b0;
        tick(); tick();
        chk("post_rresp", {25'b0, RVALID, RID, RRESP}, {25'b0, 1'b1, 4'hA, 2'b00});
        chk("post_rdata", RDATA, 32'h0BADF00D);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
